mdu_sequencer: RTL and testbench

Multi-cycle multiply sequencer that owns the HI/LO register pair behind the ALU's multiply, mfhi and mflo operations. It performs a shift-add multiply over WIDTH cycles, raises a stall to the pipeline while running, and presents HI/LO to the ALU result mux. The ALU decode drives `start` when a multiply opcode issues.

---
 rtl/mdu_pkg.sv | 13 +
 rtl/mdu_shift_add.sv | 25 ++
 rtl/mdu_sequencer.sv | 123 ++++++++++++
 tb/tb_mdu_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply sequencer (mdu_sequencer).
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  localparam int MDU_WIDTH_DEFAULT = 32;
  localparam int MDU_CNT_W         = $clog2(MDU_WIDTH_DEFAULT);

endpackage

// File: rtl/mdu_shift_add.sv
// One shift-add multiply iteration: conditional add of the multiplicand into the
// upper half of {carry, acc, multiplier}, then a right shift by one.
module mdu_shift_add #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  prod_i,
  input  logic [WIDTH-1:0]  mcand_i,
  output logic [2*WIDTH:0]  prod_o
);

  logic [WIDTH:0] sum;
  logic           unused_carry_in;

  // The carry slot is always zero on entry because the previous shift cleared it.
  assign unused_carry_in = prod_i[2*WIDTH];

  always_comb begin
    sum = {1'b0, prod_i[2*WIDTH-1:WIDTH]};
    if (prod_i[0]) begin
      sum = sum + {1'b0, mcand_i};
    end
    prod_o = {1'b0, sum, prod_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle shift-add multiplier owning the HI/LO pair; stalls the pipeline while running.
// Optional signed support is enabled by defining MDU_SIGNED_EN.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output mdu_state_t       dbg_state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  mdu_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH:0] prod_q, prod_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH:0] step;
  logic [WIDTH-1:0] op0, op1;
  logic [2*WIDTH-1:0] result;

  mdu_shift_add #(.WIDTH(WIDTH)) u_step (
    .prod_i  (prod_q),
    .mcand_i (mcand_q),
    .prod_o  (step)
  );

`ifdef MDU_SIGNED_EN
  logic sign_q, sign_d;

  // Negating the most-negative value yields 2^(WIDTH-1), the correct unsigned magnitude.
  assign op0    = (is_signed && in0[WIDTH-1]) ? -in0 : in0;
  assign op1    = (is_signed && in1[WIDTH-1]) ? -in1 : in1;
  assign result = sign_q ? -step[2*WIDTH-1:0] : step[2*WIDTH-1:0];
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign op0              = in0;
  assign op1              = in1;
  assign result           = step[2*WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_SIGNED_EN
    sign_d  = sign_q;
`endif
    unique case (state_q)
      RUN: begin
        prod_d = step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          hi_d    = result[2*WIDTH-1:WIDTH];
          lo_d    = result[WIDTH-1:0];
          state_d = DONE;
        end
      end
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          mcand_d = op0;
          prod_d  = {{(WIDTH+1){1'b0}}, op1};
          cnt_d   = '0;
          state_d = RUN;
`ifdef MDU_SIGNED_EN
          sign_d  = is_signed & (in0[WIDTH-1] ^ in1[WIDTH-1]);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MDU_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MDU_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  assign busy        = (state_q == RUN);
  assign stall       = busy;
  assign done        = (state_q == DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer (WIDTH=32); expected products are hand-computed.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] in0, in1;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo;
  mdu_state_t   dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  mdu_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .in0         (in0),
    .in1         (in1),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Accept one operation, then wait for done; returns cycles to done and busy count.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output int cyc, output int busy_cnt);
    start = 1'b1; in0 = a; in1 = b; is_signed = s;
    tick();
    start = 1'b0; in0 = '0; in1 = '0; is_signed = 1'b0;
    cyc = 0; busy_cnt = 0;
    while (!done && cyc < 100) begin
      if (busy) busy_cnt++;
      tick();
      cyc++;
    end
  endtask

  int cyc, bcnt, dcnt;
  logic [W-1:0] exp_hi_s, exp_lo_s;

  initial begin
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; in0 = '0; in1 = '0;
    tick(); tick();
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;
    tick();

    // 3 x 5
    run_op(32'd3, 32'd5, 1'b0, cyc, bcnt);
    check_eq("u3x5_latency", 64'(cyc), 64'd32);
    check_eq("u3x5_busy_cycles", 64'(bcnt), 64'd32);
    check_eq("u3x5_done", 64'(done), 64'd1);
    check_eq("u3x5_stall_low", 64'(stall), 64'd0);
    check_eq("u3x5_hi", 64'(hi), 64'h0);
    check_eq("u3x5_lo", 64'(lo), 64'hF);
    tick();
    check_eq("u3x5_done_drop", 64'(done), 64'd0);
    tick(); tick();
    check_eq("u3x5_hold_lo", 64'(lo), 64'hF);

    // All-ones squared
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, cyc, bcnt);
    check_eq("ff_hi", 64'(hi), 64'hFFFF_FFFE);
    check_eq("ff_lo", 64'(lo), 64'h0000_0001);
    tick();

    // -2 x 3 with is_signed
`ifdef MDU_SIGNED_EN
    exp_hi_s = 32'hFFFF_FFFF; exp_lo_s = 32'hFFFF_FFFA;
`else
    exp_hi_s = 32'h0000_0002; exp_lo_s = 32'hFFFF_FFFA;
`endif
    run_op(32'hFFFF_FFFE, 32'd3, 1'b1, cyc, bcnt);
    check_eq("s_m2x3_hi", 64'(hi), 64'(exp_hi_s));
    check_eq("s_m2x3_lo", 64'(lo), 64'(exp_lo_s));
    tick();

    // start pulsed mid-RUN is ignored
    start = 1'b1; in0 = 32'd11; in1 = 32'd13;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    start = 1'b1; in0 = 32'd9; in1 = 32'd9;
    tick();
    start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) dcnt++;
      tick();
    end
    check_eq("midrun_done_pulses", 64'(dcnt), 64'd1);
    check_eq("midrun_lo", 64'(lo), 64'd143);
    check_eq("midrun_hi", 64'(hi), 64'd0);

    // Back-to-back: start held during DONE
    run_op(32'd3, 32'd5, 1'b0, cyc, bcnt);
    check_eq("b2b_first_done", 64'(done), 64'd1);
    start = 1'b1; in0 = 32'd7; in1 = 32'd6;
    tick();
    start = 1'b0;
    check_eq("b2b_busy_again", 64'(busy), 64'd1);
    check_eq("b2b_done_low", 64'(done), 64'd0);
    cyc = 1;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    check_eq("b2b_gap", 64'(cyc), 64'd33);
    check_eq("b2b_lo", 64'(lo), 64'h2A);
    tick();

    // Reset mid-RUN aborts
    start = 1'b1; in0 = 32'd100; in1 = 32'd200;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check_eq("abort_pre_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_stall", 64'(stall), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    check_eq("abort_hi", 64'(hi), 64'd0);
    check_eq("abort_lo", 64'(lo), 64'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcnt++;
      tick();
    end
    check_eq("abort_no_done", 64'(dcnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
